// File: rtl/data_memory_pkg.sv
// Shared constants, byte/lane types and little-endian lane helpers for the
// 64-bit data memory.
package data_memory_pkg;

  localparam int unsigned DATA_W         = 64;
  localparam int unsigned BYTES_PER_WORD = 8;

  typedef logic [7:0] byte_t;
  typedef byte_t [BYTES_PER_WORD-1:0] lanes_t;

  // Lane k carries bits [8k+7:8k], so lane 0 lands at the base address.
  function automatic lanes_t unpack_le(input logic [DATA_W-1:0] word);
    lanes_t lanes;
    lanes = {BYTES_PER_WORD{8'h00}};
    for (int k = 0; k < int'(BYTES_PER_WORD); k++) begin
      lanes[k] = word[8*k +: 8];
    end
    return lanes;
  endfunction

  function automatic logic [DATA_W-1:0] pack_le(input lanes_t lanes);
    logic [DATA_W-1:0] word;
    word = {DATA_W{1'b0}};
    for (int k = 0; k < int'(BYTES_PER_WORD); k++) begin
      word[8*k +: 8] = lanes[k];
    end
    return word;
  endfunction

endpackage

// File: rtl/data_mem_byte_array.sv
// Byte storage: eight byte lanes at consecutive addresses from a shared base,
// synchronous per-lane write and combinational read, synchronous full clear.
module data_mem_byte_array
  import data_memory_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned IDX_W     = 11
) (
  input  logic                      clk_i,
  input  logic                      clear_i,
  input  logic [IDX_W-1:0]          base_i,
  input  logic [BYTES_PER_WORD-1:0] lane_we_i,
  input  lanes_t                    wr_lanes_i,
  output lanes_t                    rd_lanes_o
);

  localparam int unsigned AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  byte_t                     mem_q [MEM_BYTES];
  logic [IDX_W-1:0]          lane_idx_s [BYTES_PER_WORD];
  logic [BYTES_PER_WORD-1:0] lane_ok_s;

  // Lane addresses; a lane past the end is never written and reads as zero.
  always_comb begin
    lane_ok_s = {BYTES_PER_WORD{1'b0}};
    for (int k = 0; k < int'(BYTES_PER_WORD); k++) begin
      lane_idx_s[k] = base_i + IDX_W'(k);
      lane_ok_s[k]  = (lane_idx_s[k] < IDX_W'(MEM_BYTES));
    end
  end

  always_comb begin
    rd_lanes_o = {BYTES_PER_WORD{8'h00}};
    for (int k = 0; k < int'(BYTES_PER_WORD); k++) begin
      if (lane_ok_s[k]) begin
        rd_lanes_o[k] = mem_q[lane_idx_s[k][AW-1:0]];
      end else begin
        rd_lanes_o[k] = 8'h00;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      for (int unsigned i = 0; i < MEM_BYTES; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < int'(BYTES_PER_WORD); k++) begin
        if (lane_we_i[k] && lane_ok_s[k]) begin
          mem_q[lane_idx_s[k][AW-1:0]] <= wr_lanes_i[k];
        end
      end
    end
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable 64-bit data memory: little-endian doublewords at any byte
// address, synchronous write, registered read-before-write read port.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [DATA_W-1:0] read_data
);

  localparam int unsigned IDX_W = $clog2(MEM_BYTES) + 1;
  // Highest base whose eighth byte still fits; comparing against it avoids
  // the wrap that address + 7 would suffer near 2^64.
  localparam logic [DATA_W-1:0] LAST_BASE = DATA_W'(MEM_BYTES - BYTES_PER_WORD);

  logic                      in_range_s;
  logic [IDX_W-1:0]          base_s;
  logic [BYTES_PER_WORD-1:0] lane_we_s;
  lanes_t                    wr_lanes_s;
  lanes_t                    rd_lanes_s;
  logic [DATA_W-1:0]         read_data_d;
  logic [DATA_W-1:0]         read_data_q;

  always_comb begin
    in_range_s = (address <= LAST_BASE);
    base_s     = address[IDX_W-1:0];
  end

  always_comb begin
    wr_lanes_s = unpack_le(write_data);
    lane_we_s  = {BYTES_PER_WORD{1'b0}};
    if (!reset && MemWrite && in_range_s) begin
      lane_we_s = {BYTES_PER_WORD{1'b1}};
    end else begin
      lane_we_s = {BYTES_PER_WORD{1'b0}};
    end
  end

  data_mem_byte_array #(
    .MEM_BYTES (MEM_BYTES),
    .IDX_W     (IDX_W)
  ) u_bytes (
    .clk_i      (clk),
    .clear_i    (reset),
    .base_i     (base_s),
    .lane_we_i  (lane_we_s),
    .wr_lanes_i (wr_lanes_s),
    .rd_lanes_o (rd_lanes_s)
  );

  // Array read is combinational on pre-edge contents, giving read-before-write.
  always_comb begin
    read_data_d = read_data_q;
    if (MemRead) begin
      if (in_range_s) begin
        read_data_d = pack_le(rd_lanes_s);
      end else begin
        read_data_d = {DATA_W{1'b0}};
      end
    end else begin
      read_data_d = read_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_q <= {DATA_W{1'b0}};
    end else begin
      read_data_q <= read_data_d;
    end
  end

  assign read_data = read_data_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed and randomized checks of data_memory against a byte-array model.
module tb_data_memory;

  localparam int unsigned MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] address = 64'h0;
  logic [63:0] write_data = 64'h0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [63:0] read_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  ref_mem [MEM_BYTES];
  logic [63:0] exp_rd = 64'h0;

  data_memory #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .write_data (write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .read_data  (read_data)
  );

  always #5 clk = ~clk;

  function automatic bit ref_in_range(input logic [63:0] a);
    logic [64:0] last;
    last = {1'b0, a} + 65'd7;
    return last < 65'(MEM_BYTES);
  endfunction

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    logic [63:0] v;
    v = 64'h0;
    if (ref_in_range(a)) begin
      for (int i = 0; i < 8; i++) v = v | (64'(ref_mem[int'(a) + i]) << (8 * i));
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: drive, advance the model, compare the registered output.
  task automatic step(input string tag, input logic rst, input logic [63:0] a,
                      input logic [63:0] wd, input logic rd, input logic wr);
    reset = rst; address = a; write_data = wd; MemRead = rd; MemWrite = wr;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = 8'h00;
      exp_rd = 64'h0;
    end else begin
      if (rd) exp_rd = ref_read(a);
      if (wr && ref_in_range(a)) begin
        for (int i = 0; i < 8; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      end
    end
    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    check(tag, read_data, exp_rd);
  endtask

  initial begin
    for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = 8'h00;

    step("reset", 1'b1, 64'd0, 64'h0, 1'b1, 1'b1);
    check("reset_zero", read_data, 64'h0);
    step("read0_after_reset", 1'b0, 64'd0, 64'h0, 1'b1, 1'b0);
    check("read0_zero", read_data, 64'h0);

    step("write100", 1'b0, 64'd100, 64'h1122334455667788, 1'b0, 1'b1);
    step("read100", 1'b0, 64'd100, 64'h0, 1'b1, 1'b0);
    check("read100_const", read_data, 64'h1122334455667788);
    for (int i = 0; i < 10; i++) step("hold100", 1'b0, 64'd3, 64'hDEAD, 1'b0, 1'b0);
    check("hold100_const", read_data, 64'h1122334455667788);
    step("read100b", 1'b0, 64'd100, 64'h0, 1'b1, 1'b0);
    check("byte100", {56'h0, read_data[7:0]}, 64'h88);
    step("read107", 1'b0, 64'd107, 64'h0, 1'b1, 1'b0);
    check("byte107", {56'h0, read_data[7:0]}, 64'h11);

    step("writeA0", 1'b0, 64'd0, 64'hAAAAAAAAAAAAAAAA, 1'b0, 1'b1);
    step("writeB4", 1'b0, 64'd4, 64'hBBBBBBBBBBBBBBBB, 1'b0, 1'b1);
    step("read0", 1'b0, 64'd0, 64'h0, 1'b1, 1'b0);
    check("overlap_const", read_data, 64'hBBBBBBBBAAAAAAAA);

    step("write1017", 1'b0, 64'd1017, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1);
    step("read1009", 1'b0, 64'd1009, 64'h0, 1'b1, 1'b0);
    check("oor_write_ignored", read_data, 64'h0);
    step("write1016", 1'b0, 64'd1016, 64'h0102030405060708, 1'b0, 1'b1);
    step("read1017", 1'b0, 64'd1017, 64'h0, 1'b1, 1'b0);
    check("oor_read_zero", read_data, 64'h0);
    step("read1016", 1'b0, 64'd1016, 64'h0, 1'b1, 1'b0);
    check("edge1016_const", read_data, 64'h0102030405060708);
    step("read_hi", 1'b0, 64'h1_0000_0000, 64'h0, 1'b1, 1'b0);
    check("read_hi_zero", read_data, 64'h0);
    step("read1016c", 1'b0, 64'd1016, 64'h0, 1'b1, 1'b0);
    step("read_wrap", 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b1, 1'b1);
    check("read_wrap_zero", read_data, 64'h0);

    step("write200", 1'b0, 64'd200, 64'h5, 1'b0, 1'b1);
    step("rw200", 1'b0, 64'd200, 64'h9, 1'b1, 1'b1);
    check("rbw_const", read_data, 64'h5);
    step("read200", 1'b0, 64'd200, 64'h0, 1'b1, 1'b0);
    check("after_rw_const", read_data, 64'h9);

    for (int n = 0; n < 400; n++) begin
      logic [63:0] a;
      if ($urandom_range(0, 9) == 0) a = {$urandom, $urandom};
      else a = 64'($urandom_range(0, MEM_BYTES + 4));
      step("random", ($urandom_range(0, 59) == 0), a, {$urandom, $urandom},
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    step("write8", 1'b0, 64'd8, 64'h1, 1'b0, 1'b1);
    step("read8_pre", 1'b0, 64'd8, 64'h0, 1'b1, 1'b0);
    check("read8_pre_const", read_data, 64'h1);
    step("reset_mid", 1'b1, 64'd8, 64'h7, 1'b1, 1'b1);
    check("reset_mid_zero", read_data, 64'h0);
    step("read8", 1'b0, 64'd8, 64'h0, 1'b1, 1'b0);
    check("read8_zero", read_data, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Byte-addressable data memory for the 64-bit processor datapath, in the memory-access stage. Stores 64-bit doublewords little-endian across eight consecutive bytes. Writes and reads are synchronous. The registered read result holds until the next read.

## Interface
- `MEM_BYTES`, default 1024: storage size in bytes; must be ≥ 8.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `address` input 64: byte address of the least-significant byte of the doubleword.
- `write_data` input 64: doubleword to store.
- `MemRead` input 1: read enable, sampled on the rising edge.
- `MemWrite` input 1: write enable, sampled on the rising edge.
- `read_data` output 64: registered read result.

## Operation
- Storage is `MEM_BYTES` × 8-bit bytes.
- Doubleword at `A` occupies bytes `A`..`A+7`, little-endian:
  - `A` holds `data[7:0]`.
  - `A+7` holds `data[63:56]`.
- Unaligned addresses are legal, with no alignment restriction.
- An access is in range iff `address + 7 < MEM_BYTES`, computed without 64-bit wrap. Any high address bit set makes the access out of range.
- Write, on a rising edge with `MemWrite=1`, `reset=0`, and the access in range: all eight bytes are updated from `write_data`.
- Out-of-range write: ignored, and no byte changes.
- Read, on a rising edge with `MemRead=1` and `reset=0`: `read_data` is loaded with the doubleword at `address`. An out-of-range read loads `64'h0`.
- When `MemRead=0`, `read_data` holds its previous value.
- `MemRead` and `MemWrite` asserted in the same cycle at the same or overlapping addresses: the read returns the pre-write contents (read-before-write), and the write still takes effect.
- Reset has priority over read and write:
  - All `MEM_BYTES` bytes are cleared to 0.
  - `read_data` is cleared to 0.
  - A concurrent read or write in that cycle is discarded.

## Timing
- Reset value: `read_data = 0`, all bytes 0. Applied on the first rising edge with `reset=1`; there is no asynchronous effect.
- Write latency: data is stored at edge N. A read sampled at edge N+1 or later returns it.
- Read latency: one cycle. `read_data` is valid after edge N when `MemRead` is sampled high at edge N, and stays stable until the next edge with `MemRead=1` or `reset=1`.
- No handshake. Every access completes in one cycle, with no stalls.
- Reset asserted mid-sequence: contents written before the reset are lost, and reads after the reset return 0.

## Structure
- Shared package holds the `DATA_W=64` and `BYTES_PER_WORD=8` constants and a byte-type typedef.
- One sub-module, `data_mem_byte_array`: the byte storage array, with a synchronous byte-lane write enable and combinational read of eight lanes.
- The top level contains:
  - range check
  - little-endian lane packing and unpacking
  - the read register
  - reset sequencing

## Test plan
- **Reset.** Hold `reset=1` for 1 cycle → `read_data=0`. A read of address 0 after reset → 0.
- **Write then read at 100.** Write address 100, data `64'h1122334455667788`, one cycle. Then `MemRead=1` for one cycle, then deassert. Expect:
  - `read_data=64'h1122334455667788`, still held 10 cycles later.
  - Byte 100 = `8'h88`, byte 107 = `8'h11`, checked via unaligned reads.
- **Unaligned overlap.** Write `64'hAAAAAAAAAAAAAAAA` at 0 and `64'hBBBBBBBBBBBBBBBB` at 4. Read 0 → `64'hBBBBBBBBAAAAAAAA`.
- **Out of range** (default `MEM_BYTES=1024`).
  - Write at 1017 → ignored.
  - Read at 1017 → 0.
  - Read at `64'h1_0000_0000` → 0.
  - Write/read at 1016 works normally.
- **Simultaneous read/write.** Address 200 holds `64'h5`. Read and write `64'h9` in the same cycle → `read_data=5`. The next read → 9.
- **Reset mid-operation.** Write `64'h1` at 8, assert reset for 1 cycle, read 8 → 0.
